mpmodred32_shift: RTL

- Word-serial conditional modular reduction stage, directly downstream of the 256-bit word-serial adder.
- Consumes the 257-bit sum S and a 256-bit modulus P. Produces R = S − P when S ≥ P, otherwise R = S[255:0].
- Together with the adder this gives (a + b) mod p for field arithmetic.
- Processes one 32-bit limb per cycle, LSW first, with a shifted limb register file and a borrow flop.

---
 rtl/mp_pkg.sv | 17 +
 rtl/mp_word_sub.sv | 22 ++
 rtl/mpmodred32_shift.sv | 108 ++++++++++
 3 files changed

// File: rtl/mp_pkg.sv
// Shared constants and types for the 256-bit word-serial modular arithmetic stages.
package mp_pkg;

  localparam int WORD_W = 32;
  localparam int NWORDS = 8;
  localparam int OP_W   = WORD_W * NWORDS;
  localparam int CNT_W  = $clog2(NWORDS);

  typedef logic [WORD_W-1:0] limb_t;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    DONE
  } state_e;

endpackage

// File: rtl/mp_word_sub.sv
// Single-limb subtract with borrow-in and borrow-out: {bout, d} = a - b - bin.
module mp_word_sub
  import mp_pkg::*;
(
  input  limb_t a_i,
  input  limb_t b_i,
  input  logic  bin_i,
  output limb_t d_o,
  output logic  bout_o
);

  logic [WORD_W:0] diff_ext;

  // One extra bit catches the wrap-around, which is exactly the borrow out.
  always_comb begin
    diff_ext = {1'b0, a_i} - {1'b0, b_i} - {{WORD_W{1'b0}}, bin_i};
  end

  assign d_o    = diff_ext[WORD_W-1:0];
  assign bout_o = diff_ext[WORD_W];

endmodule

// File: rtl/mpmodred32_shift.sv
// Conditional modular reduction R = (S >= P) ? S - P : S[255:0], computed one
// 32-bit limb per cycle, least significant limb first, through a shifting limb file.
module mpmodred32_shift
  import mp_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [OP_W:0]   s_in,
  input  logic [OP_W-1:0] p_in,
  input  logic            start,
  output logic [OP_W-1:0] r_out,
  output logic            ready,
  output logic            busy
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q;
  logic             s_hi_q;
  logic [OP_W-1:0]  s_q;       // shifts down one limb per SUB cycle
  logic [OP_W-1:0]  p_q;       // shifts down one limb per SUB cycle
  logic [OP_W-1:0]  s_hold_q;  // untouched copy of S for the bypass result
  logic [OP_W-1:0]  diff_q;    // limbs of S - P enter at the top
  logic [OP_W-1:0]  r_q;
  logic             ready_q;
  logic             busy_q;

  limb_t d_limb;
  logic  borrow_n;
  logic  ge;

  mp_word_sub u_word_sub (
    .a_i    (s_q[WORD_W-1:0]),
    .b_i    (p_q[WORD_W-1:0]),
    .bin_i  (borrow_q),
    .d_o    (d_limb),
    .bout_o (borrow_n)
  );

  // A set bit 256 means S already exceeds any 256-bit P; otherwise no final borrow means S >= P.
  assign ge = s_hi_q | ~borrow_q;

  // Control FSM plus limb datapath; outputs are registered here.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      s_hi_q   <= 1'b0;
      // NOTE: the limb registers are cleared on reset so no stale operand survives an abort.
      s_q      <= '0;
      p_q      <= '0;
      s_hold_q <= '0;
      diff_q   <= '0;
      r_q      <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (start) begin
            s_q      <= s_in[OP_W-1:0];
            s_hold_q <= s_in[OP_W-1:0];
            s_hi_q   <= s_in[OP_W];
            p_q      <= p_in;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= SUB;
          end
        end

        SUB: begin
          diff_q   <= {d_limb, diff_q[OP_W-1:WORD_W]};
          s_q      <= {limb_t'(0), s_q[OP_W-1:WORD_W]};
          p_q      <= {limb_t'(0), p_q[OP_W-1:WORD_W]};
          borrow_q <= borrow_n;
          if (cnt_q == CNT_W'(NWORDS - 1)) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DONE: begin
          r_q     <= ge ? diff_q : s_hold_q;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign r_out = r_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule
